// File: rtl/data_mem_resp_pkg.sv
// ============================================================================
// Module      : data_mem_resp_pkg
// Description : Shared memop encodings and responder FSM states, also used by
//               the CPU load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_mem_resp_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  // Unsigned loads have no store counterpart, so they are illegal with wen=1.
  function automatic logic memop_illegal(input logic [2:0] op, input logic wen);
    logic v_bad;
    case (op)
      MEMOP_B, MEMOP_H, MEMOP_W: v_bad = 1'b0;
      MEMOP_BU, MEMOP_HU:        v_bad = wen;
      default:                   v_bad = 1'b1;
    endcase
    return v_bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_fmt.sv
// ============================================================================
// Module      : mem_lane_fmt
// Description : Combinational byte-lane formatter: store alignment, load
//               extraction/extension and misalignment detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_fmt
  import data_mem_resp_pkg::*;
(
  input  logic [2:0]  i_memop,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_word,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_store_word,
  output logic [31:0] o_load_data,
  output logic        o_align_err
);

  logic [31:0] w_byte_shift;
  logic [31:0] w_half_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte_shift = i_load_word >> {i_addr_lo, 3'b000};
  assign w_half_shift = i_load_word >> {i_addr_lo[1], 4'b0000};
  assign w_byte       = w_byte_shift[7:0];
  assign w_half       = w_half_shift[15:0];

  always_comb begin
    o_byte_en    = 4'b0000;
    o_store_word = i_store_data;
    o_load_data  = 32'h0;
    o_align_err  = 1'b0;
    case (i_memop)
      MEMOP_B: begin
        o_byte_en    = 4'b0001 << i_addr_lo;
        o_store_word = {4{i_store_data[7:0]}};
        o_load_data  = {{24{w_byte[7]}}, w_byte};
      end
      MEMOP_H: begin
        o_byte_en    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_store_word = {2{i_store_data[15:0]}};
        o_load_data  = {{16{w_half[15]}}, w_half};
        o_align_err  = i_addr_lo[0];
      end
      MEMOP_W: begin
        o_byte_en    = 4'b1111;
        o_load_data  = i_load_word;
        o_align_err  = (i_addr_lo != 2'b00);
      end
      MEMOP_BU: begin
        o_load_data  = {24'h0, w_byte};
      end
      MEMOP_HU: begin
        o_load_data  = {16'h0, w_half};
        o_align_err  = i_addr_lo[0];
      end
      default: begin
        o_byte_en    = 4'b0000;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_resp.sv
// ============================================================================
// Module      : data_mem_resp
// Description : Fixed-latency data memory responder with valid/ready request
//               and response handshakes, byte-lane stores and fault reporting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_wen,
  input  logic [2:0]  memop,
  input  logic [31:0] mem_addr,
  input  logic [31:0] memdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] mem_data,
  output logic        rsp_err
);

  localparam int          c_LAT    = (LATENCY < 1) ? 1 : ((LATENCY > 8) ? 8 : LATENCY);
  localparam logic [3:0]  c_LAT_M1 = 4'(c_LAT - 1);
  localparam int          c_AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] c_SPAN   = 33'(DEPTH_WORDS) * 33'd4;

  mem_state_e  r_state;
  mem_state_e  w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;

  logic        r_wen;
  logic [2:0]  r_memop;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept;
  logic        w_enter_resp;
  logic        w_cur_wen;
  logic [2:0]  w_cur_memop;
  logic [31:0] w_cur_addr;
  logic [31:0] w_cur_wdata;
  logic [31:0] w_offset;
  logic        w_in_range;
  logic [c_AW-1:0] w_idx;
  logic [31:0] w_rd_word;
  logic        w_op_err;
  logic        w_align_err;
  logic        w_err;
  logic        w_wr;
  logic [3:0]  w_byte_en;
  logic [31:0] w_store_word;
  logic [31:0] w_load_data;

  // With a single-cycle latency RESP is entered on the accept edge itself, so
  // the live request fields are used until the captured copy exists.
  assign w_cur_wen   = (r_state == ST_IDLE) ? mem_wen  : r_wen;
  assign w_cur_memop = (r_state == ST_IDLE) ? memop    : r_memop;
  assign w_cur_addr  = (r_state == ST_IDLE) ? mem_addr : r_addr;
  assign w_cur_wdata = (r_state == ST_IDLE) ? memdata  : r_wdata;

  assign w_offset   = w_cur_addr - BASE_ADDR;
  assign w_in_range = (w_cur_addr >= BASE_ADDR) && ({1'b0, w_offset} < c_SPAN);
  assign w_idx      = w_in_range ? w_offset[c_AW+1:2] : '0;
  assign w_rd_word  = r_mem[w_idx];
  assign w_op_err   = memop_illegal(w_cur_memop, w_cur_wen);
  assign w_err      = !w_in_range || w_op_err || w_align_err;

  mem_lane_fmt u_lane_fmt (
    .i_memop      (w_cur_memop),
    .i_addr_lo    (w_cur_addr[1:0]),
    .i_store_data (w_cur_wdata),
    .i_load_word  (w_rd_word),
    .o_byte_en    (w_byte_en),
    .o_store_word (w_store_word),
    .o_load_data  (w_load_data),
    .o_align_err  (w_align_err)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (c_LAT == 1) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = c_LAT_M1;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt = ST_RESP;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign w_accept     = (r_state == ST_IDLE) && req_valid;
  assign w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);
  // rst gating keeps a store from committing while reset is held.
  assign w_wr         = w_enter_resp && w_cur_wen && !w_err && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_wen   <= 1'b0;
      r_memop <= 3'b000;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_wen   <= mem_wen;
        r_memop <= memop;
        r_addr  <= mem_addr;
        r_wdata <= memdata;
      end
      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_cur_wen) ? 32'h0 : w_load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_byte_en[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_store_word[8*b +: 8];
        end
      end
    end
  end

  assign mem_data = r_rdata;
  assign rsp_err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_resp.sv
// ============================================================================
// Module      : tb_data_mem_resp
// Description : Self-checking bench for data_mem_resp against a behavioural
//               memory model, with directed and randomized transactions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_resp;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          LAT   = 2;
  localparam longint      c_LO  = 64'h8000_0000;
  localparam longint      c_HI  = c_LO + 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        mem_wen;
  logic [2:0]  memop;
  logic [31:0] mem_addr;
  logic [31:0] memdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] mem_data;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  data_mem_resp #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .LATENCY     (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .mem_wen   (mem_wen),
    .memop     (memop),
    .mem_addr  (mem_addr),
    .memdata   (memdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .mem_data  (mem_data),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  function automatic bit ref_err(bit wen, bit [2:0] op, bit [31:0] addr);
    longint a = longint'(addr);
    bit oor = (a < c_LO) || (a >= c_HI);
    bit bad;
    case (op)
      3'd0:    bad = 1'b0;
      3'd1:    bad = addr[0];
      3'd2:    bad = (addr[1:0] != 2'b00);
      3'd4:    bad = wen;
      3'd5:    bad = wen || addr[0];
      default: bad = 1'b1;
    endcase
    return oor || bad;
  endfunction

  function automatic bit [31:0] ref_load(bit [2:0] op, bit [31:0] addr, bit [31:0] word);
    bit [31:0] b = (word >> (8 * addr[1:0])) & 32'hFF;
    bit [31:0] h = (word >> (16 * addr[1])) & 32'hFFFF;
    case (op)
      3'd0:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd2:    return word;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit [31:0] ref_store(bit [2:0] op, bit [31:0] addr, bit [31:0] old, bit [31:0] d);
    int sh;
    bit [31:0] mask;
    case (op)
      3'd0:    begin sh = 8 * addr[1:0]; mask = 32'hFF << sh; end
      3'd1:    begin sh = 16 * addr[1];  mask = 32'hFFFF << sh; end
      default: begin sh = 0;             mask = 32'hFFFF_FFFF; end
    endcase
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  bit [31:0] m_mem   [DEPTH];
  bit        m_known [DEPTH];
  bit        m_busy;
  int        m_age;
  bit        m_wen;
  bit [2:0]  m_op;
  bit [31:0] m_addr;
  bit [31:0] m_wdata;
  bit        m_exp_err;
  bit [31:0] m_exp_data;
  bit        m_exp_known;

  task automatic model_resolve(input bit wen, input bit [2:0] op, input bit [31:0] addr, input bit [31:0] d);
    bit e;
    int idx;
    e   = ref_err(wen, op, addr);
    idx = e ? 0 : int'((addr - BASE) >> 2);
    m_exp_err   <= e;
    m_exp_data  <= (e || wen) ? 32'h0 : ref_load(op, addr, m_mem[idx]);
    m_exp_known <= e || wen || m_known[idx];
    if (!e && wen) begin
      m_mem[idx] <= ref_store(op, addr, m_mem[idx], d);
      if (op == 3'd2) m_known[idx] <= 1'b1;
    end
  endtask

  // Transaction-level timeline: age counts edges since accept, accept edge = 1.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_age  <= 0;
    end else if (m_busy) begin
      if (m_age >= LAT) begin
        if (rsp_ready) m_busy <= 1'b0;
      end else begin
        m_age <= m_age + 1;
        if (m_age + 1 == LAT) model_resolve(m_wen, m_op, m_addr, m_wdata);
      end
    end else if (req_valid) begin
      m_busy  <= 1'b1;
      m_age   <= 1;
      m_wen   <= mem_wen;
      m_op    <= memop;
      m_addr  <= mem_addr;
      m_wdata <= memdata;
      if (LAT == 1) model_resolve(mem_wen, memop, mem_addr, memdata);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_mem_data",  mem_data,       32'd0);
      chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    end else begin
      chk("req_ready", 32'(req_ready), 32'(!m_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= LAT));
      if (m_busy && m_age >= LAT) begin
        chk("rsp_err", 32'(rsp_err), 32'(m_exp_err));
        if (m_exp_known) chk("mem_data", mem_data, m_exp_data);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic garble();
    req_valid = 1'($urandom);
    mem_wen   = 1'($urandom);
    memop     = 3'($urandom);
    mem_addr  = $urandom;
    memdata   = $urandom;
  endtask

  task automatic issue(input bit wen, input bit [2:0] op, input bit [31:0] addr, input bit [31:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    mem_wen   = wen;
    memop     = op;
    mem_addr  = addr;
    memdata   = d;
    rsp_ready = 1'($urandom);
    for (int i = 0; i < 20; i++) begin
      if (req_ready) break;
      @(negedge clk);
    end
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic txn(input bit wen, input bit [2:0] op, input bit [31:0] addr, input bit [31:0] d,
                     input int hold, output logic [31:0] rd, output logic re, output int lat);
    issue(wen, op, addr, d);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
      garble();
      rsp_ready = 1'($urandom);
    end
    if (!rsp_valid) chk("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      garble();
      rsp_ready = 1'b0;
    end
    rd = mem_data;
    re = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  function automatic bit [31:0] pick_addr();
    int r = $urandom_range(0, 9);
    bit [31:0] lane = 32'($urandom_range(0, 3));
    if (r < 7)  return BASE + 32'(4 * $urandom_range(0, 15)) + lane;
    if (r == 7) return BASE + 32'(4 * $urandom_range(1020, 1023)) + lane;
    if (r == 8) return ($urandom_range(0, 1) != 0) ? (BASE + 32'h1000 + lane) : (BASE - 32'd4 + lane);
    return $urandom;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;
    bit [2:0]    legal_ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rst = 1'b0; req_valid = 1'b0; mem_wen = 1'b0; memop = 3'd0;
    mem_addr = 32'h0; memdata = 32'h0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int w = 0; w < 16; w++) txn(1'b1, 3'd2, BASE + 32'(4 * w), $urandom, 0, d, e, lat);
    for (int w = 1020; w < 1024; w++) txn(1'b1, 3'd2, BASE + 32'(4 * w), $urandom, 0, d, e, lat);

    txn(1'b1, 3'd2, 32'h8000_0000, 32'hDEAD_BEEF, 0, d, e, lat);
    txn(1'b0, 3'd2, 32'h8000_0000, 32'h0, 0, d, e, lat);
    chk("lw_data", d, 32'hDEAD_BEEF);
    chk("lw_err", 32'(e), 32'd0);
    chk("lw_latency", 32'(lat), 32'd2);
    txn(1'b0, 3'd0, 32'h8000_0003, 32'h0, 0, d, e, lat); chk("lb", d, 32'hFFFF_FFDE);
    txn(1'b0, 3'd4, 32'h8000_0003, 32'h0, 0, d, e, lat); chk("lbu", d, 32'h0000_00DE);
    txn(1'b0, 3'd1, 32'h8000_0002, 32'h0, 0, d, e, lat); chk("lh", d, 32'hFFFF_DEAD);
    txn(1'b0, 3'd5, 32'h8000_0002, 32'h0, 0, d, e, lat); chk("lhu", d, 32'h0000_DEAD);
    txn(1'b1, 3'd0, 32'h8000_0001, 32'h11, 0, d, e, lat); chk("sb_data", d, 32'h0);
    txn(1'b0, 3'd2, 32'h8000_0000, 32'h0, 0, d, e, lat); chk("sb_merge", d, 32'hDEAD_11EF);

    txn(1'b0, 3'd2, 32'h8000_0002, 32'h0, 0, d, e, lat);
    chk("lw_misalign_err", 32'(e), 32'd1); chk("lw_misalign_data", d, 32'h0);
    txn(1'b1, 3'd1, 32'h8000_0001, 32'hFFFF, 0, d, e, lat); chk("sh_misalign_err", 32'(e), 32'd1);
    txn(1'b0, 3'd2, 32'h7FFF_FFFC, 32'h0, 0, d, e, lat);
    chk("lw_below_err", 32'(e), 32'd1); chk("lw_below_data", d, 32'h0);
    txn(1'b1, 3'd3, 32'h8000_0000, 32'h0, 0, d, e, lat); chk("op011_err", 32'(e), 32'd1);
    txn(1'b1, 3'd4, 32'h8000_0000, 32'h0, 0, d, e, lat); chk("sbu_err", 32'(e), 32'd1);
    txn(1'b1, 3'd2, 32'h8000_1000, 32'h0, 0, d, e, lat); chk("sw_top_err", 32'(e), 32'd1);
    txn(1'b0, 3'd2, 32'h8000_0FFC, 32'h0, 0, d, e, lat); chk("lw_last_err", 32'(e), 32'd0);
    txn(1'b0, 3'd2, 32'h8000_0000, 32'h0, 5, d, e, lat);
    chk("hold_data_unchanged", d, 32'hDEAD_11EF); chk("hold_err", 32'(e), 32'd0);

    for (int n = 0; n < 300; n++) begin
      bit [2:0] op = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 4)] : 3'($urandom);
      txn(1'($urandom), op, pick_addr(), $urandom, $urandom_range(0, 3), d, e, lat);
    end

    txn(1'b1, 3'd2, 32'h8000_0010, 32'h0, 0, d, e, lat);
    issue(1'b1, 3'd2, 32'h8000_0010, 32'h1234_5678);
    @(negedge clk);
    req_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_mem_data",  mem_data,       32'd0);
    chk("abort_rsp_err",   32'(rsp_err),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    txn(1'b0, 3'd2, 32'h8000_0010, 32'h0, 0, d, e, lat);
    chk("abort_no_write", d, 32'h0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
